// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, default timing and the
// debug view of the transmitter FSM. Kept separate so a receiver can reuse it.
package uart_pkg;

   // 50 MHz system clock / 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DEFAULT_FIFO_DEPTH   = 4;

   // Transmitter FSM states (plain constants so older tools can read them)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Snapshot of the transmitter internals for checkers
   typedef struct packed {
      logic [1:0]  state;
      logic [2:0]  bit_idx;
      logic [15:0] baud_cnt;
   } tx_dbg_t;

   // Width of a counter that must hold values 0..n-1 (at least one bit)
   function automatic int ctr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO. Pointers wrap modulo DEPTH (power of two); a separate
// occupancy count distinguishes full from empty. Push while full and pop
// while empty are ignored, so callers may drive them unguarded.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [7:0]       wr_data,
   input  logic             pop,
   output logic [7:0]       rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = ctr_width(DEPTH);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop nets to zero
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write; contents need no reset because the count gates every read
   always_ff @(posedge clock) begin
      if (!reset && do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front.
// Handshake: a byte is taken on every rising edge where tx_valid and tx_ready
// are both high; tx_ready depends only on FIFO fullness, never on tx_valid.
// ser_tx is registered; the start bit appears the cycle after the FSM pops.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       ser_tx,
   output logic       busy,
   output tx_dbg_t    dbg
);

   localparam int BAUD_W = ctr_width(CLKS_PER_BIT);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]        state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
   logic              baud_end;

   logic              fifo_pop;
   logic [7:0]        fifo_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (tx_valid),
      .wr_data (tx_data),
      .pop     (fifo_pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign baud_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   // Pop when idle, or at the end of a stop bit so frames run back to back
   assign fifo_pop = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

   assign tx_ready = !fifo_full;
   assign busy     = (state != ST_IDLE) || (fifo_count != '0);
   assign dbg      = '{state: state, bit_idx: bit_idx, baud_cnt: 16'(baud_cnt)};

   // Frame sequencer: walks START, eight DATA bits LSB first, STOP
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         ser_tx   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               ser_tx   <= 1'b1;
               if (!fifo_empty) begin
                  shift  <= fifo_data;
                  state  <= ST_START;
                  ser_tx <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= ST_DATA;
                  ser_tx   <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            ST_DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state  <= ST_STOP;
                     ser_tx <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     // next bit is what becomes shift[0] after this shift
                     ser_tx  <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            ST_STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (!fifo_empty) begin
                     shift  <= fifo_data;
                     state  <= ST_START;
                     ser_tx <= 1'b0;
                  end else begin
                     state  <= ST_IDLE;
                     ser_tx <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               ser_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a queue-based line model predicts ser_tx, tx_ready and
// busy every cycle; a serial decoder recovers bytes from the line; a second
// instance at 434 clocks per bit carries a short text message.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CPB_B = 434;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, ser_tx, busy;
   tx_dbg_t    dbg_a;

   logic       reset_b = 1'b1;
   logic [7:0] tx_data_b = '0;
   logic       tx_valid_b = 1'b0;
   logic       tx_ready_b, ser_tx_b, busy_b;
   tx_dbg_t    dbg_b;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // model state
   logic [7:0] pend[$];     // bytes accepted but not yet on the line
   logic       line_q[$];   // remaining per-cycle levels of the current frame
   logic [7:0] exp_q[$];    // bytes whose frames started, awaiting the decoder
   logic       m_ser = 1'b1;
   logic       m_in_frame = 1'b0;
   int         rst_epoch = 0;

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .ser_tx(ser_tx), .busy(busy), .dbg(dbg_a)
   );

   uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
      .clock(clock), .reset(reset_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
      .tx_ready(tx_ready_b), .ser_tx(ser_tx_b), .busy(busy_b), .dbg(dbg_b)
   );

   // clock
   always #5 clock = ~clock;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // line model: a frame is 10 bit slots of CPB cycles; a new frame starts on
   // the first edge where the line is free and a byte is already queued
   always @(posedge clock) begin
      logic acc;
      logic [7:0] b;
      if (reset) begin
         pend.delete();
         line_q.delete();
         exp_q.delete();
         m_ser = 1'b1;
         m_in_frame = 1'b0;
         rst_epoch++;
      end else begin
         acc = tx_valid && (pend.size() < DEPTH);
         if (line_q.size() == 0 && pend.size() > 0) begin
            b = pend.pop_front();
            exp_q.push_back(b);
            for (int s = 0; s < 10; s++)
               for (int c = 0; c < CPB; c++)
                  line_q.push_back((s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1]);
         end
         if (line_q.size() > 0) begin
            m_ser = line_q.pop_front();
            m_in_frame = 1'b1;
         end else begin
            m_ser = 1'b1;
            m_in_frame = 1'b0;
         end
         if (acc) pend.push_back(tx_data);
      end
   end

   // per-cycle compare against the model
   always @(negedge clock) begin
      if (chk_en) begin
         check("ser_tx", ser_tx, m_ser);
         check("tx_ready", tx_ready, pend.size() < DEPTH);
         check("busy", busy, m_in_frame || (pend.size() != 0));
      end
   end

   // wait n falling edges, giving up early if a reset edge occurs
   task automatic wait_a(input int n, input int ep, output bit aborted);
      aborted = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         if (ep != rst_epoch) begin
            aborted = 1;
            return;
         end
      end
   endtask

   // serial decoder for instance A, scoreboarded against exp_q
   initial begin : rx_a
      logic [7:0] b;
      logic st, sp;
      int ep;
      bit ab;
      forever begin
         @(negedge clock);
         if (reset || ser_tx !== 1'b0) continue;
         ep = rst_epoch;
         wait_a(CPB / 2, ep, ab);
         if (ab) continue;
         st = ser_tx;
         for (int i = 0; i < 8 && !ab; i++) begin
            wait_a(CPB, ep, ab);
            b[i] = ser_tx;
         end
         if (ab) continue;
         wait_a(CPB, ep, ab);
         if (ab) continue;
         sp = ser_tx;
         check("rx_start_bit", st, 1'b0);
         check("rx_stop_bit", sp, 1'b1);
         if (exp_q.size() == 0) check("rx_unexpected_byte", b, 32'hFFFF_FFFF);
         else check("rx_byte", b, exp_q.pop_front());
      end
   end

   // driver: single-cycle push, waits (bounded) for tx_ready
   task automatic push_byte(input logic [7:0] d);
      int t = 0;
      tx_data = d;
      tx_valid = 1'b1;
      while (!tx_ready && t < 500) begin
         @(negedge clock);
         t++;
      end
      if (t >= 500) check("push_timeout", 0, 1);
      @(negedge clock);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 3000) begin
         @(negedge clock);
         t++;
      end
      check("idle_timeout", busy, 1'b0);
   endtask

   task automatic rx_b(output logic [7:0] b, output bit ok);
      int t = 0;
      logic st, sp;
      b = '0;
      ok = 0;
      while (ser_tx_b !== 1'b0 && t < 6000) begin
         @(negedge clock);
         t++;
      end
      if (t >= 6000) return;
      repeat (CPB_B / 2) @(negedge clock);
      st = ser_tx_b;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB_B) @(negedge clock);
         b[i] = ser_tx_b;
      end
      repeat (CPB_B) @(negedge clock);
      sp = ser_tx_b;
      ok = (st == 1'b0) && (sp == 1'b1);
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [9:0] pat;
      logic [7:0] stream [6];
      logic [7:0] msg [3];
      logic [7:0] rb;
      string rx_str;
      int full_at, t;
      bit ok;

      // reset block
      repeat (3) @(negedge clock);
      check("reset_ser_tx", ser_tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_tx_ready", tx_ready, 1'b1);
      check("reset_state", dbg_a.state, ST_IDLE);
      reset = 1'b0;
      reset_b = 1'b0;
      chk_en = 1;
      repeat (2) @(negedge clock);

      // single 0x55 frame, literal waveform
      pat = 10'b1010101010;
      push_byte(8'h55);
      check("lit_idle_on_accept", ser_tx, 1'b1);
      @(negedge clock);
      for (int j = 0; j < 10 * CPB; j++) begin
         check("lit_0x55_wave", ser_tx, pat[j / CPB]);
         @(negedge clock);
      end
      check("lit_busy_after_frame", busy, 1'b0);
      repeat (3) @(negedge clock);

      // stream with tx_valid held; 0x77 arrives while full
      stream = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h77};
      full_at = -1;
      for (int i = 0; i < 6; i++) begin
         tx_data = stream[i];
         tx_valid = 1'b1;
         t = 0;
         while (!tx_ready && t < 500) begin
            if (full_at < 0) full_at = i;
            @(negedge clock);
            t++;
         end
         @(negedge clock);
      end
      tx_valid = 1'b0;
      check("lit_pushes_before_full", full_at, 5);
      wait_idle();

      // reset in the middle of a 0xC3 frame with bytes queued
      push_byte(8'hC3);
      push_byte(8'h11);
      push_byte(8'h22);
      repeat (11) @(negedge clock);
      reset = 1'b1;
      tx_valid = 1'b1;
      tx_data = 8'h99;
      @(negedge clock);
      check("lit_abort_ser_tx", ser_tx, 1'b1);
      check("lit_abort_busy", busy, 1'b0);
      check("lit_abort_tx_ready", tx_ready, 1'b1);
      reset = 1'b0;
      tx_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("lit_no_accept_in_reset", busy, 1'b0);
      push_byte(8'h12);
      wait_idle();

      // push landing exactly on the STOP-to-START edge
      push_byte(8'hA1);
      push_byte(8'hB2);
      repeat (10 * CPB - 1) @(negedge clock);
      push_byte(8'hC4);
      wait_idle();

      // randomized traffic with occasional resets
      for (int c = 0; c < 4000; c++) begin
         tx_valid = ($urandom_range(0, 9) < 3);
         tx_data = 8'($urandom);
         reset = ($urandom_range(0, 999) == 0);
         @(negedge clock);
      end
      reset = 1'b0;
      tx_valid = 1'b0;
      wait_idle();
      repeat (4) @(negedge clock);
      check("rx_all_decoded", exp_q.size(), 0);

      // second instance: "OK\n" at 434 clocks per bit
      check("b_tx_ready", tx_ready_b, 1'b1);
      check("b_state_idle", dbg_b.state, ST_IDLE);
      msg = '{8'h4F, 8'h4B, 8'h0A};
      for (int i = 0; i < 3; i++) begin
         tx_data_b = msg[i];
         tx_valid_b = 1'b1;
         @(negedge clock);
      end
      tx_valid_b = 1'b0;
      rx_str = "";
      for (int i = 0; i < 3; i++) begin
         rx_b(rb, ok);
         check("b_frame_ok", ok, 1'b1);
         check("b_char", rb, msg[i]);
         rx_str = {rx_str, string'(rb)};
      end
      $write("monitor_rx: %s", rx_str);
      repeat (CPB_B) @(negedge clock);
      check("b_busy_end", busy_b, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data is valid this cycle.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port ser_tx  output  1  serial line, idle high; 8N1, LSB first.
REQ-009 SHALL have port busy  output  1  a frame is on the line or the FIFO is non-empty.

Function
REQ-010 SHALL accept a byte on every rising edge where tx_valid and tx_ready are both high; no byte SHALL be accepted otherwise.
REQ-011 SHALL drive tx_ready = not FIFO full, combinationally from FIFO state only, never from tx_valid.
REQ-012 SHALL hold tx_ready low when the FIFO is full; tx_valid while full SHALL be ignored with no overwrite.
REQ-013 SHALL store bytes in FIFO order; read and write pointers SHALL wrap modulo FIFO_DEPTH, with a separate occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-014 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-015 IDLE: ser_tx=1; on any edge with FIFO non-empty, SHALL pop the head byte into the shift register, clear the baud counter and enter START.
REQ-016 START: ser_tx=0 for exactly CLKS_PER_BIT cycles, then SHALL enter DATA with bit index 0.
REQ-017 DATA: ser_tx = shift register bit 0 for CLKS_PER_BIT cycles per bit, then shift right; after bit index 7 SHALL enter STOP.
REQ-018 STOP: ser_tx=1 for CLKS_PER_BIT cycles; at the end SHALL pop and enter START directly if the FIFO is non-empty (no idle gap), otherwise enter IDLE.
REQ-019 ser_tx SHALL be a registered output: the start bit SHALL appear one cycle after the edge that accepts a byte into an empty FIFO while in IDLE.
REQ-020 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be contiguous.
REQ-021 A push and a pop on the same edge SHALL leave occupancy unchanged; this is legal even at FIFO_DEPTH-1 occupancy.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary.
REQ-023 busy SHALL be high when state is not IDLE or occupancy is non-zero, and low otherwise.

Reset
REQ-024 On reset high at a rising edge: state=IDLE, ser_tx=1, FIFO emptied (pointers and count = 0), baud and bit counters = 0, busy=0, tx_ready=1 from the next cycle.
REQ-025 Reset during a frame SHALL abort it: ser_tx=1 on the following cycle; queued bytes SHALL be discarded; no partial frame SHALL resume.
REQ-026 tx_valid during reset SHALL NOT be accepted.

Structure
REQ-027 State encoding and the default CLKS_PER_BIT constant SHALL live in the shared package uart_pkg, for reuse by a future synthesizable receiver.
REQ-028 The FIFO SHALL be a separate sub-module uart_tx_fifo (push/pop/full/empty/count) instantiated once.
REQ-029 The FSM, counters and shift register SHALL be in uart_tx itself; no latches and no combinational path from tx_valid to any output.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-030 Single byte 0x55 pushed while idle -> ser_tx low starting 1 cycle later, then bits 1,0,1,0,1,0,1,0 and stop 1, each 4 cycles; busy low 40 cycles after the start bit begins.
REQ-031 Push 0x00, 0xFF, 0xA5, 0x3C, 0x81 with tx_valid held high -> tx_ready drops after 5 pushes (4 queued + 1 in flight), all 5 frames contiguous (200 cycles), received in order by a bench monitor_rx-style decoder.
REQ-032 FIFO full and tx_valid high with 0x77 -> 0x77 not transmitted until tx_ready rises; no queued byte corrupted.
REQ-033 Reset asserted at cycle 13 of a 0xC3 frame -> ser_tx=1 next cycle, busy=0, FIFO empty; next push 0x12 transmits cleanly.
REQ-034 CLKS_PER_BIT=434 at 50 MHz, send "OK\n" -> monitor_rx at 115200 baud prints "OK" plus a newline.
REQ-035 Push exactly at the STOP-to-START boundary -> occupancy remains correct, with no lost or duplicated byte.
